// File: rtl/fetch_sequencer.sv
// fetch_sequencer: multicycle instruction fetch controller upstream of the PC register.
//
// Reads the current PC, fetches the word at that address through a ready
// handshake, and presents it to the decoder. Once the decoder accepts the word,
// it computes the next PC (sequential or taken branch) and pulses the PC load
// strobe. A watchdog sets a sticky fault if memory never answers.
//
// Ports:
//   clk          system clock, rising edge
//   reset        synchronous active-low reset
//   pc_current   current PC register value
//   mem_addr     instruction memory address (registered)
//   mem_rd       read request, held until mem_ready
//   mem_rdata    read data, valid with mem_ready
//   mem_ready    memory completion strobe
//   instr        fetched instruction word
//   instr_valid  instr awaits the decoder
//   instr_ack    decoder accepts instr
//   br_taken     branch taken, sampled with instr_ack
//   br_target    branch target, sampled with instr_ack
//   halt         stop fetching after the current instruction retires
//   next_pc      PC register load value
//   pc_en        PC load strobe, one-cycle registered pulse
//   fault        sticky memory-timeout flag
module fetch_sequencer #(
   parameter int unsigned PC_W        = 16,
   parameter int unsigned INSTR_W     = 16,
   parameter int unsigned PC_INC      = 1,
   parameter int unsigned MEM_TIMEOUT = 15
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [PC_W-1:0]    pc_current,
   output logic [PC_W-1:0]    mem_addr,
   output logic               mem_rd,
   input  logic [INSTR_W-1:0] mem_rdata,
   input  logic               mem_ready,
   output logic [INSTR_W-1:0] instr,
   output logic               instr_valid,
   input  logic               instr_ack,
   input  logic               br_taken,
   input  logic [PC_W-1:0]    br_target,
   input  logic               halt,
   output logic [PC_W-1:0]    next_pc,
   output logic               pc_en,
   output logic               fault
);

   typedef enum logic [2:0] {
      StIdle,
      StFetch,
      StWait,
      StHold,
      StUpdate,
      StSettle
   } state_e;

   localparam logic [7:0]      TimeoutCnt = 8'(MEM_TIMEOUT);
   localparam logic [PC_W-1:0] PcInc      = PC_W'(PC_INC);

   state_e             state_q, state_d;
   logic [PC_W-1:0]    mem_addr_q, mem_addr_d;
   logic               mem_rd_q, mem_rd_d;
   logic [INSTR_W-1:0] instr_q, instr_d;
   logic               instr_valid_q, instr_valid_d;
   logic [PC_W-1:0]    next_pc_q, next_pc_d;
   logic               pc_en_q, pc_en_d;
   logic               fault_q, fault_d;
   logic [7:0]         cnt_q, cnt_d;
   logic [7:0]         cnt_inc;

   assign cnt_inc = cnt_q + 8'd1;

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q       <= StIdle;
         mem_addr_q    <= '0;
         mem_rd_q      <= 1'b0;
         instr_q       <= '0;
         instr_valid_q <= 1'b0;
         next_pc_q     <= '0;
         pc_en_q       <= 1'b0;
         fault_q       <= 1'b0;
         cnt_q         <= '0;
      end else begin
         state_q       <= state_d;
         mem_addr_q    <= mem_addr_d;
         mem_rd_q      <= mem_rd_d;
         instr_q       <= instr_d;
         instr_valid_q <= instr_valid_d;
         next_pc_q     <= next_pc_d;
         pc_en_q       <= pc_en_d;
         fault_q       <= fault_d;
         cnt_q         <= cnt_d;
      end
   end

   always_comb begin
      state_d       = state_q;
      mem_addr_d    = mem_addr_q;
      mem_rd_d      = mem_rd_q;
      instr_d       = instr_q;
      instr_valid_d = instr_valid_q;
      next_pc_d     = next_pc_q;
      // pc_en is a pulse: it only rises on an accepted instruction.
      pc_en_d       = 1'b0;
      fault_d       = fault_q;
      cnt_d         = cnt_q;

      unique case (state_q)
         StIdle: begin
            if (!halt && !fault_q) state_d = StFetch;
         end
         StFetch: begin
            mem_addr_d = pc_current;
            mem_rd_d   = 1'b1;
            cnt_d      = '0;
            state_d    = StWait;
         end
         StWait: begin
            // A ready on the final watchdog cycle still completes the read.
            if (mem_ready) begin
               instr_d       = mem_rdata;
               instr_valid_d = 1'b1;
               mem_rd_d      = 1'b0;
               state_d       = StHold;
            end else begin
               cnt_d = cnt_inc;
               if (cnt_inc == TimeoutCnt) begin
                  fault_d  = 1'b1;
                  mem_rd_d = 1'b0;
                  state_d  = StIdle;
               end
            end
         end
         StHold: begin
            if (instr_ack) begin
               instr_valid_d = 1'b0;
               next_pc_d     = br_taken ? br_target : mem_addr_q + PcInc;
               pc_en_d       = 1'b1;
               state_d       = StUpdate;
            end
         end
         StUpdate: begin
            state_d = StSettle;
         end
         StSettle: begin
            state_d = halt ? StIdle : StFetch;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   assign mem_addr    = mem_addr_q;
   assign mem_rd      = mem_rd_q;
   assign instr       = instr_q;
   assign instr_valid = instr_valid_q;
   assign next_pc     = next_pc_q;
   assign pc_en       = pc_en_q;
   assign fault       = fault_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: directed vector table, multi-cycle
// corner sequences, then randomized transactions against a spec-level model.
module tb_fetch_sequencer;

   localparam int PC_W        = 16;
   localparam int INSTR_W     = 16;
   localparam int PC_INC      = 1;
   localparam int MEM_TIMEOUT = 15;

   logic               clk = 1'b0;
   logic               reset = 1'b0;
   logic [PC_W-1:0]    pc_current = '0;
   logic [PC_W-1:0]    mem_addr;
   logic               mem_rd;
   logic [INSTR_W-1:0] mem_rdata = '0;
   logic               mem_ready = 1'b0;
   logic [INSTR_W-1:0] instr;
   logic               instr_valid;
   logic               instr_ack = 1'b0;
   logic               br_taken = 1'b0;
   logic [PC_W-1:0]    br_target = '0;
   logic               halt = 1'b0;
   logic [PC_W-1:0]    next_pc;
   logic               pc_en;
   logic               fault;

   int checks = 0;
   int failures = 0;
   int cyc = 0;

   fetch_sequencer #(
      .PC_W       (PC_W),
      .INSTR_W    (INSTR_W),
      .PC_INC     (PC_INC),
      .MEM_TIMEOUT(MEM_TIMEOUT)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .pc_current (pc_current),
      .mem_addr   (mem_addr),
      .mem_rd     (mem_rd),
      .mem_rdata  (mem_rdata),
      .mem_ready  (mem_ready),
      .instr      (instr),
      .instr_valid(instr_valid),
      .instr_ack  (instr_ack),
      .br_taken   (br_taken),
      .br_target  (br_target),
      .halt       (halt),
      .next_pc    (next_pc),
      .pc_en      (pc_en),
      .fault      (fault)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endfunction

   // Spec-level model: sequential word address with PC_W-bit wrap, or branch target.
   function automatic logic [PC_W-1:0] model_next(logic [PC_W-1:0] pc, bit taken,
                                                  logic [PC_W-1:0] target);
      int unsigned seq;
      seq = (int'(pc) + PC_INC) % (1 << PC_W);
      return taken ? target : PC_W'(seq);
   endfunction

   typedef struct {
      logic [PC_W-1:0]    pc;
      int                 rdy_dly;
      logic [INSTR_W-1:0] rdata;
      int                 ack_dly;
      bit                 taken;
      logic [PC_W-1:0]    target;
      logic [PC_W-1:0]    exp_next;
   } vec_t;

   task automatic do_reset();
      instr_ack = 1'b0;
      mem_ready = 1'b0;
      halt      = 1'b0;
      reset     = 1'b0;
      @(negedge clk);
      chk("rst_mem_rd", 32'(mem_rd), 0);
      chk("rst_mem_addr", 32'(mem_addr), 0);
      chk("rst_instr", 32'(instr), 0);
      chk("rst_instr_valid", 32'(instr_valid), 0);
      chk("rst_next_pc", 32'(next_pc), 0);
      chk("rst_pc_en", 32'(pc_en), 0);
      chk("rst_fault", 32'(fault), 0);
      reset = 1'b1;
   endtask

   // Wait (bounded) for a read request; pc_en must stay low meanwhile.
   task automatic wait_rd(output bit ok);
      int n = 0;
      while (mem_rd !== 1'b1 && n < 12) begin
         @(negedge clk);
         chk("pc_en_quiet", 32'(pc_en), 0);
         n++;
      end
      ok = (mem_rd === 1'b1);
      if (!ok) chk("fetch_start_timeout", 32'(mem_rd), 1);
   endtask

   // One full instruction transaction. rdy_dly = idle WAIT cycles before ready;
   // any value >= MEM_TIMEOUT means memory never answers in time.
   task automatic do_instr(input logic [PC_W-1:0] pc, input int rdy_dly,
                           input logic [INSTR_W-1:0] rdata, input int ack_dly,
                           input bit taken, input logic [PC_W-1:0] target,
                           input logic [PC_W-1:0] exp_next, input bit halt_in_wait,
                           output int rd_cycle);
      bit ok;
      bit exp_fault;
      exp_fault  = (rdy_dly >= MEM_TIMEOUT);
      pc_current = pc;
      mem_ready  = 1'b0;
      instr_ack  = 1'b0;
      rd_cycle   = -1;
      wait_rd(ok);
      if (!ok) return;
      rd_cycle = cyc;
      chk("mem_addr", 32'(mem_addr), 32'(pc));
      if (halt_in_wait) halt = 1'b1;
      for (int i = 0; i <= rdy_dly && i < MEM_TIMEOUT; i++) begin
         bit done;
         bit timed;
         done      = (i == rdy_dly);
         timed     = !done && (i == MEM_TIMEOUT - 1);
         mem_ready = done;
         mem_rdata = done ? rdata : INSTR_W'($urandom);
         instr_ack = done ? 1'b0 : 1'($urandom);
         @(negedge clk);
         chk("wait_mem_rd", 32'(mem_rd), 32'(!(done || timed)));
         chk("wait_fault", 32'(fault), 32'(timed));
         chk("wait_valid", 32'(instr_valid), 32'(done));
         chk("wait_addr_stable", 32'(mem_addr), 32'(pc));
         chk("wait_pc_en", 32'(pc_en), 0);
      end
      mem_ready = 1'b0;
      instr_ack = 1'b0;
      if (exp_fault) begin
         for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            chk("fault_no_rd", 32'(mem_rd), 0);
            chk("fault_no_pc_en", 32'(pc_en), 0);
            chk("fault_sticky", 32'(fault), 1);
         end
         return;
      end
      chk("instr", 32'(instr), 32'(rdata));
      for (int j = 0; j <= ack_dly; j++) begin
         bit last;
         last      = (j == ack_dly);
         instr_ack = last;
         br_taken  = last ? taken : !taken;
         br_target = last ? target : PC_W'($urandom);
         mem_ready = 1'($urandom);
         mem_rdata = INSTR_W'($urandom);
         @(negedge clk);
         if (!last) begin
            chk("hold_valid", 32'(instr_valid), 1);
            chk("hold_instr", 32'(instr), 32'(rdata));
            chk("hold_pc_en", 32'(pc_en), 0);
         end else begin
            chk("ack_pc_en", 32'(pc_en), 1);
            chk("next_pc", 32'(next_pc), 32'(exp_next));
            chk("ack_valid", 32'(instr_valid), 0);
         end
      end
      instr_ack = 1'b0;
      br_taken  = 1'b0;
      mem_ready = 1'b0;
      @(negedge clk);
      chk("pc_en_pulse_end", 32'(pc_en), 0);
      chk("next_pc_held", 32'(next_pc), 32'(exp_next));
   endtask

   initial begin
      vec_t vecs[6];
      int   rc, prev_rc;
      bit   ok;

      vecs[0] = '{16'h0000, 0, 16'h1234, 0, 1'b0, 16'h0000, 16'h0001};
      vecs[1] = '{16'h0010, 0, 16'hA5A5, 2, 1'b1, 16'h0200, 16'h0200};
      vecs[2] = '{16'h0010, 1, 16'h5A5A, 1, 1'b0, 16'h0300, 16'h0011};
      vecs[3] = '{16'hFFFF, 5, 16'hBEEF, 3, 1'b0, 16'h1111, 16'h0000};
      vecs[4] = '{16'h7FFF, MEM_TIMEOUT - 1, 16'hC0DE, 0, 1'b0, 16'h2222, 16'h8000};
      vecs[5] = '{16'h0123, 2, 16'h0F0F, 1, 1'b1, 16'hFFFF, 16'hFFFF};

      repeat (2) @(negedge clk);
      do_reset();

      foreach (vecs[v]) begin
         do_instr(vecs[v].pc, vecs[v].rdy_dly, vecs[v].rdata, vecs[v].ack_dly, vecs[v].taken,
                  vecs[v].target, vecs[v].exp_next, 1'b0, rc);
      end

      // Sustained cadence: no stalls gives one fetch every 5 cycles.
      prev_rc = -1;
      for (int k = 0; k < 4; k++) begin
         do_instr(PC_W'(k), 0, INSTR_W'(16'h1000 + k), 0, 1'b0, '0, PC_W'(k + 1), 1'b0, rc);
         if (k > 0) chk("cadence", 32'(rc - prev_rc), 5);
         prev_rc = rc;
      end

      // Timeout: never ready -> fault after MEM_TIMEOUT WAIT cycles, then parked.
      do_instr(16'h0400, MEM_TIMEOUT, 16'h0, 0, 1'b0, '0, '0, 1'b0, rc);
      do_reset();

      // Halt raised during WAIT: instruction completes, then the block parks.
      do_instr(16'h0500, 1, 16'h4444, 1, 1'b0, '0, 16'h0501, 1'b1, rc);
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         chk("halt_parked_rd", 32'(mem_rd), 0);
         chk("halt_parked_pc_en", 32'(pc_en), 0);
      end
      halt = 1'b0;
      do_instr(16'h0501, 0, 16'h5555, 0, 1'b1, 16'h0042, 16'h0042, 1'b0, rc);

      // Reset during WAIT abandons the read; fetch restarts from pc_current.
      pc_current = 16'h0040;
      wait_rd(ok);
      do_reset();
      do_instr(16'h0050, 0, 16'h6666, 0, 1'b0, '0, 16'h0051, 1'b0, rc);

      // Reset during HOLD drops the pending instruction.
      pc_current = 16'h0060;
      wait_rd(ok);
      mem_ready = 1'b1;
      mem_rdata = 16'h7777;
      @(negedge clk);
      mem_ready = 1'b0;
      chk("hold_before_reset", 32'(instr_valid), 1);
      do_reset();
      do_instr(16'h0070, 0, 16'h8888, 0, 1'b0, '0, 16'h0071, 1'b0, rc);

      // Randomized transactions against the model.
      for (int k = 0; k < 40; k++) begin
         logic [PC_W-1:0]    pc;
         logic [PC_W-1:0]    tgt;
         logic [INSTR_W-1:0] rd;
         int                 rdy;
         bit                 tk;
         pc  = PC_W'($urandom);
         tgt = PC_W'($urandom);
         rd  = INSTR_W'($urandom);
         tk  = 1'($urandom);
         rdy = ($urandom_range(0, 7) == 0) ? MEM_TIMEOUT + int'($urandom_range(0, 3))
                                           : int'($urandom_range(0, MEM_TIMEOUT - 1));
         do_instr(pc, rdy, rd, int'($urandom_range(0, 4)), tk, tgt, model_next(pc, tk, tgt),
                  1'b0, rc);
         if (rdy >= MEM_TIMEOUT) do_reset();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1);
   end

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Multicycle fetch controller sitting directly upstream of the program counter register.
- Reads the current PC value and fetches the instruction word at that address from instruction memory via a ready handshake.
- Presents the word to the decoder, then computes the next PC: sequential or taken-branch target.
- Drives the PC register's load value and load-enable strobe; a timeout watchdog flags a memory that never answers.

Parameters:
- PC_W, 16, width of PC, memory address and next-PC value.
- INSTR_W, 16, instruction word width.
- PC_INC, 1, sequential PC increment (word-addressed memory).
- MEM_TIMEOUT, 15, max cycles waiting for mem_ready before fault; legal range 1..255.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  synchronous, active-low reset (0 = reset), sampled on rising clk.
- pc_current  in  PC_W  current PC register output.
- mem_addr  out  PC_W  instruction memory address.
- mem_rd  out  1  read request, held until mem_ready.
- mem_rdata  in  INSTR_W  read data, valid when mem_ready=1.
- mem_ready  in  1  memory completion strobe.
- instr  out  INSTR_W  fetched instruction word.
- instr_valid  out  1  instr holds a valid word awaiting decoder.
- instr_ack  in  1  decoder accepts instr.
- br_taken  in  1  branch/jump taken; sampled with instr_ack.
- br_target  in  PC_W  branch target; sampled with instr_ack.
- halt  in  1  stop fetching after current instruction retires.
- next_pc  out  PC_W  load value for PC register.
- pc_en  out  1  PC load strobe; registered, one-cycle pulse.
- fault  out  1  sticky memory-timeout flag.

Behaviour:
- Reset (reset=0 at a clk edge): state=IDLE; mem_rd=0, mem_addr=0, instr=0, instr_valid=0, next_pc=0, pc_en=0, fault=0, timeout counter=0. Reset has priority over every other input in any state, including mid-fetch; an outstanding memory read is abandoned.
- All outputs are registered; pc_en must be glitch-free (PC register loads on its rising edge).
- IDLE: if halt=0 and fault=0, go to FETCH next cycle; else stay.
- FETCH (1 cycle): mem_addr<=pc_current, mem_rd<=1, counter<=0, go to WAIT.
- WAIT:
  - mem_rd held at 1 and mem_addr stable.
  - If mem_ready=1: instr<=mem_rdata, instr_valid<=1, mem_rd<=0, go to HOLD.
  - Else counter increments; when counter reaches MEM_TIMEOUT without mem_ready: fault<=1, mem_rd<=0, go to IDLE.
  - mem_ready in the same cycle the timeout would fire wins: no fault.
- HOLD: instr and instr_valid held stable until instr_ack=1. On ack:
  - instr_valid<=0.
  - next_pc<=br_target if br_taken=1, else mem_addr+PC_INC, truncated to PC_W (0xFFFF+1 wraps to 0x0000).
  - pc_en<=1; go to UPDATE.
  - br_taken and br_target are ignored when instr_ack=0.
- UPDATE (1 cycle): pc_en<=0; go to SETTLE.
- SETTLE (1 cycle): lets pc_current reflect the new value; then IDLE if halt=1, else FETCH.
- Latency, no stall, mem_ready one cycle after request: FETCH 1 + WAIT 1 + HOLD>=1 + UPDATE 1 + SETTLE 1, i.e. 5 cycles per instruction minimum.
- Exactly one pc_en pulse per acknowledged instruction; pc_en never asserted in any other state.
- halt: sampled only in IDLE and SETTLE; never aborts a fetch in progress or an unacknowledged instruction.
- fault: sticky until reset; while set the block stays in IDLE with no memory requests.
- mem_ready outside WAIT is ignored. instr_ack outside HOLD is ignored.

Test Plan:
- Reset then sequential run: pc_current=0x0000, mem_ready 1 cycle after mem_rd, rdata=0x1234, ack immediately -> mem_addr=0x0000, instr=0x1234, next_pc=0x0001, single pc_en pulse; 5-cycle cadence sustained over 4 instructions.
- Taken branch: pc_current=0x0010, ack with br_taken=1, br_target=0x0200 -> next_pc=0x0200; repeat with br_taken=0 -> next_pc=0x0011; br_taken toggled while ack=0 has no effect.
- Wrap and stall: pc_current=0xFFFF, mem_ready delayed 5 cycles, ack delayed 3 cycles -> mem_rd and mem_addr stable throughout, instr stable while valid, next_pc=0x0000.
- Timeout: mem_ready never asserted -> fault=1 exactly after MEM_TIMEOUT WAIT cycles, mem_rd=0, no pc_en, no further mem_rd until reset; mem_ready arriving on the boundary cycle -> no fault.
- Halt: assert halt during WAIT -> instruction completes, pc_en pulses once, FSM parks in IDLE with mem_rd=0; deassert -> fetch resumes at the new pc_current.
- Reset mid-operation: reset=0 during WAIT and during HOLD -> next edge all outputs at reset values, no pc_en; after release fetch restarts from pc_current.
